// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, data-SRAM request, HI/LO and a radix-2 restoring divider.
// Define EX_MULT_EN to add the single-cycle mult/multu path.
module ex_stage #(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic [172:0]       id_to_ex_bus,
    output logic [83:0]        ex_to_mem_bus,
    output logic [37:0]        ex_to_rf_bus,
    output logic [7:0]         memop_to_id,
    output logic               stallreq_for_ex,
    output logic               data_sram_en,
    output logic [3:0]         data_sram_wen,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    logic [172:0] ex_q, ex_d;
    logic [5:0]   md_op;
    logic [7:0]   mem_op;
    logic [31:0]  pc, inst, rs_val, rt_val;
    logic [11:0]  alu_op;
    logic [2:0]   sel_src1;
    logic [3:0]   sel_src2, ram_wen, lane_wen;
    logic         ram_en, rf_we, sel_rf_res;
    logic [4:0]   rf_waddr;
    logic [31:0]  src1, src2, alu_res, sra_res, ex_result;
    logic [31:0]  hi_q, hi_d, lo_q, lo_d;

    always_comb ex_d = (stall[2] && !stall[3]) ? '0 : !stall[2] ? id_to_ex_bus : ex_q;

    always_ff @(posedge clk) ex_q <= rst ? '0 : ex_d;

    assign {md_op, mem_op, pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rs_val, rt_val} = ex_q;

    always_comb begin
        src1 = sel_src1[0] ? rs_val : sel_src1[1] ? pc : sel_src1[2] ? {27'b0, inst[10:6]} : '0;
        src2 = sel_src2[0] ? rt_val : sel_src2[1] ? {{16{inst[15]}}, inst[15:0]} :
               sel_src2[2] ? 32'd8 : sel_src2[3] ? {16'b0, inst[15:0]} : '0;
    end

    // kept separate so the ternary chain below cannot strip the signedness
    assign sra_res = $signed(src2) >>> src1[4:0];

    always_comb
        alu_res = alu_op[11] ? src1 + src2 :
                  alu_op[10] ? src1 - src2 :
                  alu_op[9]  ? {31'b0, $signed(src1) < $signed(src2)} :
                  alu_op[8]  ? {31'b0, src1 < src2} :
                  alu_op[7]  ? src1 & src2 :
                  alu_op[6]  ? ~(src1 | src2) :
                  alu_op[5]  ? src1 | src2 :
                  alu_op[4]  ? src1 ^ src2 :
                  alu_op[3]  ? src2 << src1[4:0] :
                  alu_op[2]  ? src2 >> src1[4:0] :
                  alu_op[1]  ? sra_res :
                  alu_op[0]  ? {inst[15:0], 16'b0} : '0;

    assign ex_result = md_op[1] ? hi_q : md_op[0] ? lo_q : alu_res;

    always_comb begin
        lane_wen = mem_op[0] ? 4'hF :
                   mem_op[1] ? (alu_res[1] ? 4'hC : 4'h3) :
                   mem_op[2] ? 4'b0001 << alu_res[1:0] : 4'h0;
        data_sram_wdata = mem_op[1] ? {2{rt_val[15:0]}} : mem_op[2] ? {4{rt_val[7:0]}} : rt_val;
        data_sram_addr  = alu_res;
        data_sram_en    = ram_en && !stallreq_for_ex;
        data_sram_wen   = stallreq_for_ex ? 4'h0 : lane_wen;
    end

    assign ex_to_mem_bus = {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};
    assign memop_to_id   = mem_op;

    div_state_e  state_q, state_d;
    logic        div_go, div_load, div_step, div_commit, last;
    logic [31:0] rem_q, quo_q, dvs_q, hi_div, lo_div;
    logic [4:0]  cnt_q;
    logic        negq_q, negr_q, dz_q, a_neg, b_neg, fits;
    logic [32:0] trial, diff;

    assign div_go = md_op[5] || md_op[4];
    assign last   = cnt_q == 5'd31;

    always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

    always_comb
        state_d = state_q == IDLE ? (div_go ? BUSY : IDLE) :
                  state_q == BUSY ? (last ? DONE : BUSY) :
                  stall[2] ? DONE : IDLE;

    always_comb begin
        div_load        = state_q == IDLE && div_go;
        div_step        = state_q == BUSY;
        div_commit      = state_q == DONE && !stall[2];
        stallreq_for_ex = div_load || div_step;
    end

    assign a_neg = md_op[5] && rs_val[31];
    assign b_neg = md_op[5] && rt_val[31];
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};
    assign fits  = trial >= {1'b0, dvs_q};

    always_ff @(posedge clk)
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else if (div_load) begin
            rem_q  <= '0;
            quo_q  <= a_neg ? -rs_val : rs_val;
            dvs_q  <= b_neg ? -rt_val : rt_val;
            cnt_q  <= '0;
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
            dz_q   <= rt_val == '0;
        end else if (div_step) begin
            rem_q <= fits ? diff[31:0] : trial[31:0];
            quo_q <= {quo_q[30:0], fits};
            cnt_q <= cnt_q + 5'd1;
        end

    // a zero divisor leaves the dividend in the remainder, so only LO needs overriding
    assign lo_div = dz_q ? '1 : negq_q ? -quo_q : quo_q;
    assign hi_div = negr_q ? -rem_q : rem_q;

`ifdef EX_MULT_EN
    logic        mul_go;
    logic [63:0] prod;
    assign mul_go = (md_op[3] || md_op[2]) && !stall[2];
    assign prod   = md_op[3] ? $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val})
                             : {32'b0, rs_val} * {32'b0, rt_val};
    assign hi_d = div_commit ? hi_div : mul_go ? prod[63:32] : hi_q;
    assign lo_d = div_commit ? lo_div : mul_go ? prod[31:0] : lo_q;
`else
    assign hi_d = div_commit ? hi_div : hi_q;
    assign lo_d = div_commit ? lo_div : lo_q;
`endif

    always_ff @(posedge clk) begin
        hi_q <= rst ? '0 : hi_d;
        lo_q <= rst ? '0 : lo_d;
    end

    logic unused_bits;
    assign unused_bits = ^{stall, inst[31:16], mem_op[7:3], md_op[3:2], diff[32]};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [172:0] id_bus;
    logic [83:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic [7:0]   memop_to_id;
    logic         stallreq_for_ex, data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    int           n_cmp = 0, n_bad = 0;
    logic [31:0]  m_hi = 0, m_lo = 0;

    ex_stage #(.STALL_W(6)) dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .ex_to_rf_bus(ex_to_rf_bus), .memop_to_id(memop_to_id),
        .stallreq_for_ex(stallreq_for_ex), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [83:0] got, input logic [83:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [172:0] mk(input logic [5:0] md, input logic [7:0] mo,
                                        input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] alu, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren, input logic [3:0] rwen,
                                        input logic we, input logic [4:0] wa, input logic srr,
                                        input logic [31:0] rs, input logic [31:0] rt);
        return {md, mo, pc, inst, alu, s1, s2, ren, rwen, we, wa, srr, rs, rt};
    endfunction

    function automatic logic [31:0] ref_src1(input int sel, input logic [31:0] rs, input logic [31:0] pc,
                                             input logic [31:0] inst);
        if (sel == 0) return rs;
        if (sel == 1) return pc;
        return (inst >> 6) & 32'd31;
    endfunction

    function automatic logic [31:0] ref_src2(input int sel, input logic [31:0] rt, input logic [31:0] inst);
        int imm;
        imm = int'($signed(inst[15:0]));
        if (sel == 0) return rt;
        if (sel == 1) return 32'(imm);
        if (sel == 2) return 32'd8;
        return inst & 32'hFFFF;
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b,
                                            input logic [15:0] imm);
        longint bs;
        bs = longint'($signed(b));
        case (op)
            11: return a + b;
            10: return a - b;
            9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            8:  return (a < b) ? 32'd1 : 32'd0;
            7:  return a & b;
            6:  return ~(a | b);
            5:  return a | b;
            4:  return a ^ b;
            3:  return b << (a % 32);
            2:  return b >> (a % 32);
            1:  return 32'(bs >> (a % 32));
            default: return {imm, 16'h0};
        endcase
    endfunction

    // k indexes mem_op: 0 sw, 1 sh, 2 sb, 3 lw, 7 lb; address computed by add rs + sext(off)
    task automatic mem_issue(input int k, input logic [31:0] rs, input logic [15:0] off, input logic [31:0] rt);
        id_bus = mk(6'b0, 8'b1 << k, 32'h0, {16'h0, off}, 12'b1 << 11, 3'b001, 4'b0010,
                    1'b1, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt);
        step;
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        longint qa, qb;
        id_bus = mk(sgn ? 6'b100000 : 6'b010000, 8'h0, 32'h0, 32'h0, 12'h0, 3'h0, 4'h0,
                    1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
        stall = 6'b0;
        step;
        cyc = 0;
        while (stallreq_for_ex && cyc < 100) begin
            cyc++;
            if (cyc == 5) check({tag, "_en_gated"}, {data_sram_en, data_sram_wen}, 5'b0);
            stall = 6'b001111;
            step;
        end
        check({tag, "_stall_cycles"}, cyc, 33);
        if (b == 0) begin
            m_lo = 32'hFFFFFFFF;
            m_hi = a;
        end else if (sgn) begin
            qa = longint'($signed(a));
            qb = longint'($signed(b));
            m_lo = 32'(qa / qb);
            m_hi = 32'(qa % qb);
        end else begin
            m_lo = a / b;
            m_hi = a % b;
        end
        step;
        step;
        check({tag, "_done_hold"}, stallreq_for_ex, 1'b0);
        stall = 6'b0;
        id_bus = mk(6'b000001, 8'h0, 32'h0, 32'h0, 12'h0, 3'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 0, 0);
        step;
        check({tag, "_mflo"}, ex_to_rf_bus[31:0], m_lo);
        id_bus = mk(6'b000010, 8'h0, 32'h0, 32'h0, 12'h0, 3'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 0, 0);
        step;
        check({tag, "_mfhi"}, ex_to_rf_bus[31:0], m_hi);
    endtask

    initial begin
        int op, s1, s2, k;
        logic [31:0] rs, rt, pc, inst, res, addr, ew, wd;
        logic [15:0] off;
        logic [4:0] wa;
        logic [3:0] rwen, wen;
        logic we, srr;
        int kinds[5];
        kinds = '{0, 1, 2, 3, 7};

        rst = 1'b1;
        stall = 6'b0;
        id_bus = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        step;
        step;
        check("rst_mem", ex_to_mem_bus, 84'h0);
        check("rst_rf", ex_to_rf_bus, 38'h0);
        check("rst_memop", memop_to_id, 8'h0);
        check("rst_sram", {stallreq_for_ex, data_sram_en, data_sram_wen, data_sram_addr}, 38'h0);
        rst = 1'b0;

        id_bus = mk(6'b0, 8'h0, 32'h0, 32'h0000F0F0, 12'b1 << 5, 3'b001, 4'b1000,
                    1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'h00001234, 32'h0);
        step;
        check("ori_rf", ex_to_rf_bus, {1'b1, 5'd9, 32'h0000F2F4});

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 11);
            s1 = $urandom_range(0, 2);
            s2 = $urandom_range(0, 3);
            rs = $urandom; rt = $urandom; pc = $urandom; inst = $urandom;
            wa = 5'($urandom); rwen = 4'($urandom); we = 1'($urandom); srr = 1'($urandom);
            id_bus = mk(6'b0, 8'h0, pc, inst, 12'b1 << op, 3'b1 << s1, 4'b1 << s2,
                        1'b0, rwen, we, wa, srr, rs, rt);
            step;
            res = ref_alu(op, ref_src1(s1, rs, pc, inst), ref_src2(s2, rt, inst), inst[15:0]);
            check("alu_rf", ex_to_rf_bus, {we, wa, res});
            check("alu_mem", ex_to_mem_bus, {8'h0, pc, 1'b0, rwen, srr, we, wa, res});
            check("alu_addr", data_sram_addr, res);
        end

        mem_issue(2, 32'h100, 16'd3, 32'hAABBCCDD);
        check("sb_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
              {1'b1, 4'b1000, 32'h103, 32'hDDDDDDDD});
        mem_issue(1, 32'h100, 16'd2, 32'hAABBCCDD);
        check("sh_req", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
              {1'b1, 4'b1100, 32'h102, 32'hCCDDCCDD});

        for (int i = 0; i < 24; i++) begin
            k = kinds[$urandom_range(0, 4)];
            rs = $urandom; rt = $urandom; off = 16'($urandom);
            mem_issue(k, rs, off, rt);
            addr = rs + ref_src2(1, 0, {16'h0, off});
            wen = k == 0 ? 4'hF : k == 1 ? 4'(4'b0011 << (((addr >> 1) & 1) * 2)) :
                  k == 2 ? 4'(4'b0001 << (addr % 4)) : 4'h0;
            ew = k == 1 ? (rt & 32'hFFFF) * 32'h00010001 : k == 2 ? (rt & 32'hFF) * 32'h01010101 : rt;
            check("mem_addr", data_sram_addr, addr);
            check("mem_en_wen", {data_sram_en, data_sram_wen}, {1'b1, wen});
            check("mem_memop", memop_to_id, 8'b1 << k);
            if (k < 3) check("mem_wdata", data_sram_wdata, ew);
        end

        stall = 6'b000111;
        mem_issue(3, 32'h2000, 16'h10, 32'h0);
        check("bubble_mem", ex_to_mem_bus, 84'h0);
        check("bubble_rf", {ex_to_rf_bus, memop_to_id, data_sram_en}, 47'h0);
        stall = 6'b0;
        mem_issue(3, 32'h2000, 16'h10, 32'h0);
        wd = data_sram_addr;
        stall = 6'b001111;
        mem_issue(0, 32'h5000, 16'h4, 32'h1);
        check("hold_memop", memop_to_id, 8'b00001000);
        check("hold_addr", wd, 32'h2010);
        check("hold_addr_now", data_sram_addr, 32'h2010);
        stall = 6'b0;

        do_div(1'b1, 32'hFFFFFFF9, 32'd2, "div_neg7_2");
        do_div(1'b0, 32'h80000000, 32'd0, "divu_by0");
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        for (int i = 0; i < 4; i++)
            do_div(1'($urandom), $urandom, i == 3 ? 32'd0 : $urandom >> $urandom_range(0, 28), "div_rand");

        id_bus = mk(6'b100000, 8'h0, 32'h0, 32'h0, 12'h0, 3'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                    32'd100, 32'd7);
        step;
        stall = 6'b001111;
        for (int i = 0; i < 10; i++) step;
        check("busy_before_rst", stallreq_for_ex, 1'b1);
        rst = 1'b1;
        step;
        check("rst_busy_stallreq", stallreq_for_ex, 1'b0);
        check("rst_busy_bus", ex_to_mem_bus, 84'h0);
        rst = 1'b0;
        stall = 6'b0;
        m_hi = 0;
        m_lo = 0;
        id_bus = mk(6'b000010, 8'h0, 32'h0, 32'h0, 12'h0, 3'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 0, 0);
        step;
        check("rst_mfhi", ex_to_rf_bus[31:0], m_hi);
        check("rst_idle", stallreq_for_ex, 1'b0);
        id_bus = mk(6'b000001, 8'h0, 32'h0, 32'h0, 12'h0, 3'h0, 4'h0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 0, 0);
        step;
        check("rst_mflo", ex_to_rf_bus[31:0], m_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of ID and upstream of MEM.
- Registers the ID→EX bus and computes the ALU result, then issues the data-SRAM request for loads and stores.
- Drives the EX forwarding bus and the memop bus back to ID.
- Owns the HI/LO registers and a multi-cycle radix-2 divider that stalls the pipeline while it runs.

Parameters:
- STALL_W, 6, width of stall bus; bit 2 = EX, bit 3 = MEM.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  pipeline stall vector
- id_to_ex_bus  in  173  {md_op[172:167], mem_op[166:159], pc[158:127], inst[126:95], alu_op[94:83], sel_src1[82:80], sel_src2[79:76], ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rs_val[63:32], rt_val[31:0]}
- ex_to_mem_bus  out  84  {mem_op 8, pc 32, ram_en 1, ram_wen 4, sel_rf_res 1, rf_we 1, rf_waddr 5, ex_result 32}
- ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result}
- memop_to_id  out  8  registered mem_op, for ID load-use detection
- stallreq_for_ex  out  1  divider busy
- data_sram_en  out  1
- data_sram_wen  out  4  byte lanes
- data_sram_addr  out  32
- data_sram_wdata  out  32

Behaviour:
- Field encodings (one-hot):
  - md_op = {div, divu, mult, multu, mfhi, mflo}
  - alu_op bit 11..0 = {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}
  - mem_op = {lb, lbu, lh, lhu, lw, sb, sh, sw}
- Input register update, priority order:
  - rst → 0.
  - stall[2]=1 & stall[3]=0 → 0 (bubble).
  - stall[2]=0 → latch id_to_ex_bus.
  - Otherwise hold.
- src1 select: rs_val (bit0), pc (bit1), zero-extended inst[10:6] (bit2).
- src2 select: rt_val (bit0), sign-extended inst[15:0] (bit1), 32'd8 (bit2), zero-extended inst[15:0] (bit3).
- ALU operations:
  - Shifts compute src2 shifted by src1[4:0]; sra is arithmetic.
  - slt is signed; sltu is unsigned.
  - lui returns {inst[15:0], 16'b0}.
  - add and sub are wrapping; no overflow trap.
- ex_result selection: mfhi → HI, mflo → LO, else ALU result.
- Outputs ex_to_mem_bus, ex_to_rf_bus and memop_to_id are combinational from the input register. All are 0 after reset or for a bubble.
- Data SRAM request (combinational; MEM receives read data one cycle later):
  - addr = ALU result (rs + sext offset); data_sram_en = ram_en.
  - lw/sw are word accesses; sh/lh use addr[1]; sb/lb use addr[1:0].
  - sw → wen 4'b1111.
  - sh → wen 4'b0011 or 4'b1100; wdata = {2{rt[15:0]}}.
  - sb → wen = 1 << addr[1:0]; wdata = {4{rt[7:0]}}.
  - Loads → wen 0.
  - en and wen are forced to 0 while stallreq_for_ex=1.
- Divider FSM, states IDLE / BUSY / DONE:
  - IDLE → BUSY when div or divu is valid in EX. The first cycle loads operands (magnitudes for div) and counter = 0.
  - BUSY: one restoring iteration per cycle for 32 iterations → DONE.
  - stallreq_for_ex=1 combinationally in the IDLE detection cycle and through all of BUSY, i.e. exactly 33 cycles. It is 0 in DONE.
  - DONE → IDLE on the cycle the instruction advances (stall[2]=0). HI/LO are written once, at that edge. If a downstream stall holds the instruction in DONE, there is no rewrite and no restart.
  - Signed fix-up: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = dividend; still 33 stall cycles.
  - Results: LO = quotient, HI = remainder.
- A div in EX blocks memop/forwarding changes only through the stall hold. Its rf_we is 0 (ID drives it so).
- Reset at any time: FSM → IDLE, counter 0, HI = LO = 0, stallreq 0, all outputs 0.

Optional Feature:
- Macro: EX_MULT_EN.
- Defined: mult/multu compute a 64-bit product in one cycle (signed/unsigned). HI = product[63:32] and LO = product[31:0] are written when the instruction advances. No stall request.
- Undefined: mult/multu bits are ignored and HI/LO are unchanged; no multiplier logic is synthesised.

Test Plan:
- ori, rs_val=0x00001234, imm=0xF0F0 → ex_result=0x0000F2F4, rf_we=1 on ex_to_rf_bus in the same cycle as latch.
- sb, rs=0x100, off=3, rt=0xAABBCCDD → data_sram_addr=0x103, wen=4'b1000, wdata=0xDDDDDDDD; sh at offset 2 → wen=4'b1100, wdata=0xCCDDCCDD.
- div, rs=-7 (0xFFFFFFF9), rt=2 → stallreq_for_ex high for 33 cycles; following mflo → 0xFFFFFFFD, mfhi → 0xFFFFFFFF.
- divu, rs=0x80000000, rt=0 → LO=0xFFFFFFFF, HI=0x80000000; same 33-cycle stall.
- stall=6'b000111 with a valid lw in ID → next cycle EX bubble: all outputs 0, memop_to_id=0. stall=6'b001111 → register held.
- rst asserted in BUSY cycle 10 → next cycle stallreq_for_ex=0, FSM IDLE, HI=LO=0; mfhi afterwards returns 0.
